// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// Valid/ready handshake on both sides; control fields read as zero on bubbles.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_PSR,
  input  logic              rst_PSR,
  input  logic              flush_PSR,
  input  logic              in_valid_PSR,
  output logic              in_ready_PSR,
  input  logic [DATA_W-1:0] in_data_PSR,
  input  logic [CTRL_W-1:0] in_ctrl_PSR,
  output logic              out_valid_PSR,
  input  logic              out_ready_PSR,
  output logic [DATA_W-1:0] out_data_PSR,
  output logic [CTRL_W-1:0] out_ctrl_PSR,
  output logic [1:0]        count_PSR
);

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire;

  assign out_valid_PSR = (state_q != EMPTY);
  assign count_PSR     = state_q;
  assign out_data_PSR  = head_data_q;
  assign out_ctrl_PSR  = out_valid_PSR ? head_ctrl_q : '0;

  // With a skid entry, ready depends only on registered state, which breaks
  // the combinational out_ready -> in_ready path.
  generate
    if (HAS_SKID) begin : g_skid_rdy
      assign in_ready_PSR = (state_q != TWO);
    end else begin : g_stall_rdy
      assign in_ready_PSR = ~out_valid_PSR | out_ready_PSR;
    end
  endgenerate

  assign in_fire  = in_valid_PSR & in_ready_PSR;
  assign out_fire = out_valid_PSR & out_ready_PSR;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d     = ONE;
          head_data_d = in_data_PSR;
          head_ctrl_d = in_ctrl_PSR;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_data_d = in_data_PSR;
          head_ctrl_d = in_ctrl_PSR;
        end else if (in_fire && HAS_SKID) begin
          state_d     = TWO;
          skid_data_d = in_data_PSR;
          skid_ctrl_d = in_ctrl_PSR;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything held plus any entry arriving this cycle.
    if (flush_PSR) state_d = EMPTY;
  end

  always_ff @(posedge clk_PSR or posedge rst_PSR) begin
    if (rst_PSR) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: skid build checked cycle-by-cycle
// against a queue model, stall build exercised with directed steps.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    count;

  logic          flush0 = 1'b0;
  logic          in_valid0 = 1'b0;
  logic          in_ready0;
  logic [DW-1:0] in_data0 = '0;
  logic [CW-1:0] in_ctrl0 = '0;
  logic          out_valid0;
  logic          out_ready0 = 1'b0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    count0;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  ent_t q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk_PSR(clk), .rst_PSR(rst), .flush_PSR(flush),
    .in_valid_PSR(in_valid), .in_ready_PSR(in_ready),
    .in_data_PSR(in_data), .in_ctrl_PSR(in_ctrl),
    .out_valid_PSR(out_valid), .out_ready_PSR(out_ready),
    .out_data_PSR(out_data), .out_ctrl_PSR(out_ctrl), .count_PSR(count)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
    .clk_PSR(clk), .rst_PSR(rst), .flush_PSR(flush0),
    .in_valid_PSR(in_valid0), .in_ready_PSR(in_ready0),
    .in_data_PSR(in_data0), .in_ctrl_PSR(in_ctrl0),
    .out_valid_PSR(out_valid0), .out_ready_PSR(out_ready0),
    .out_data_PSR(out_data0), .out_ctrl_PSR(out_ctrl0), .count_PSR(count0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: queue holds the entries the stage should be holding, head first.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      automatic bit of = (q.size() != 0) && out_ready;
      automatic bit inf = in_valid && (q.size() < 2);
      chk("count", 128'(count), 128'(q.size()));
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      if (q.size() != 0) begin
        chk("out_data", 128'(out_data), 128'(q[0].d));
        chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
      end else begin
        chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      end
      if (of) void'(q.pop_front());
      if (flush) q.delete();
      else if (inf) q.push_back('{d: in_data, c: in_ctrl});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bubbles;
    bit got;
    // Reset values while reset held
    #12;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #3;
    rst = 1'b0;
    mon_en = 1'b1;

    // Streaming: one-cycle latency, count stays 1
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      drive(DW'(i), CW'(i));
      #1;
      if (i > 1) chk("stream_data", 128'(out_data), 128'(i - 1));
    end
    drain();

    // Bubble in a stream with all-ones control
    bubbles = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 3 || i == 7) in_valid = 1'b0;
      else drive(DW'(100 + i), 8'hFF);
      #1;
      if (i >= 1 && !out_valid) begin
        bubbles++;
        chk("bubble_ctrl_zero", 128'(out_ctrl), 128'(0));
      end
    end
    chk("bubble_count", 128'(bubbles), 128'(1));
    drain();

    // Backpressure: A head, B skid, C held upstream
    out_ready = 1'b0;
    step(); drive(96'hA, 8'h1A);
    step(); drive(96'hB, 8'h1B);
    step(); drive(96'hC, 8'h1C);
    #1;
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_count", 128'(count), 128'(2));
    repeat (3) step();
    chk("bp_hold_head", 128'(out_data), 128'(96'hA));
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (in_ready) got = 1'b1;
    end
    chk("bp_c_accept", 128'(got), 128'(1));
    step();
    in_valid = 1'b0;
    drain();
    chk("bp_drained", 128'(q.size()), 128'(0));

    // Flush with count 2 and a same-cycle input D
    out_ready = 1'b0;
    step(); drive(96'h11, 8'h21);
    step(); drive(96'h22, 8'h22);
    step(); drive(96'hDD, 8'hDD); flush = 1'b1;
    step(); in_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    drain();

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      step();
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 40) == 0;
      in_data   = {$urandom, $urandom, $urandom};
      in_ctrl   = CW'($urandom);
    end
    drain();

    // SKID=0 build: stall and replace-in-place
    step(); in_valid0 = 1'b1; in_data0 = 96'h55; in_ctrl0 = 8'h05; out_ready0 = 1'b0;
    step(); in_valid0 = 1'b0;
    #1;
    chk("s0_count", 128'(count0), 128'(1));
    chk("s0_in_ready_stall", 128'(in_ready0), 128'(0));
    chk("s0_data", 128'(out_data0), 128'(96'h55));
    in_valid0 = 1'b1; in_data0 = 96'h66; in_ctrl0 = 8'h06; out_ready0 = 1'b1;
    #1;
    chk("s0_in_ready_pass", 128'(in_ready0), 128'(1));
    step(); in_valid0 = 1'b0;
    #1;
    chk("s0_replace_data", 128'(out_data0), 128'(96'h66));
    chk("s0_replace_ctrl", 128'(out_ctrl0), 128'(8'h06));
    chk("s0_replace_count", 128'(count0), 128'(1));
    step();
    #1;
    chk("s0_empty_count", 128'(count0), 128'(0));
    chk("s0_empty_ctrl", 128'(out_ctrl0), 128'(0));

    // Asynchronous reset mid-operation with count 2
    out_ready = 1'b0;
    step(); drive(96'h77, 8'h77);
    step(); drive(96'h88, 8'h88);
    step(); in_valid = 1'b0;
    #1;
    chk("pre_rst_count", 128'(count), 128'(2));
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_count", 128'(count), 128'(0));
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_ctrl", 128'(out_ctrl), 128'(0));
    chk("arst_data", 128'(out_data), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    q.delete();
    step(); #2;
    rst = 1'b0;
    mon_en = 1'b1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    step(); drive(96'h99, 8'h99);
    step(); in_valid = 1'b0;
    #1;
    chk("post_rst_capture", 128'(out_data), 128'(96'h99));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
